// File: rtl/dac_frame_arbiter.sv
// dac_frame_arbiter: round-robin arbiter serialising 12-bit samples from four requesters onto a DAC serial port
module dac_frame_arbiter #(
    parameter int GAP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [11:0] din0,
    input  logic [11:0] din1,
    input  logic [11:0] din2,
    input  logic [11:0] din3,
    output logic [3:0]  ack,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        cs,
    output logic        sclk,
    output logic        data
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [15:0] frame_q;
    logic [1:0]  last_q;
    logic [1:0]  pick_d;
    logic [1:0]  idx_d;
    logic [11:0] din_d;
    logic [3:0]  ack_q;
    logic [3:0]  grant_q;
    logic        busy_q;
    logic        cs_q;
    logic        sclk_q;
    logic        data_q;

    // round-robin search: nearest requester after the last owner wins
    always_comb begin
        pick_d = 2'd0;
        idx_d  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx_d = last_q + 2'd1 + 2'(k);
            if (req[idx_d]) pick_d = idx_d;
        end
    end

    assign din_d = pick_d == 2'd0 ? din0 : pick_d == 2'd1 ? din1 : pick_d == 2'd2 ? din2 : din3;

    // frame sequencer: every pin is registered; reset aborts a frame in flight without ack
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frame_q <= '0;
            last_q  <= 2'd3;
            ack_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            data_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        frame_q <= {4'b0000, din_d};
                        last_q  <= pick_d;
                        grant_q <= 4'b0001 << pick_d;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b0;
                        sclk_q  <= 1'b1;
                        data_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= GAP;
                        cnt_q   <= '0;
                        ack_q   <= grant_q;
                        grant_q <= '0;
                        cs_q    <= 1'b1;
                        sclk_q  <= 1'b1;
                        data_q  <= 1'b0;
                    end else begin
                        sclk_q <= ~sclk_q;
                        if (!sclk_q) begin
                            data_q  <= frame_q[14];
                            frame_q <= {frame_q[14:0], 1'b0};
                        end
                    end
                end
                GAP: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(GAP_CYCLES - 1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack   = ack_q;
    assign grant = grant_q;
    assign busy  = busy_q;
    assign cs    = cs_q;
    assign sclk  = sclk_q;
    assign data  = data_q;
endmodule

// File: tb/tb_dac_frame_arbiter.sv
// tb_dac_frame_arbiter: directed vector bench for the DAC frame arbiter
module tb_dac_frame_arbiter;
    localparam int GAP = 2;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] din0, din1, din2, din3;
    logic [3:0]  ack, grant;
    logic        busy, cs, sclk, data;
    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]  r;
        logic [3:0]  g;
        logic [11:0] w;
    } vec_t;
    vec_t tab[6];

    dac_frame_arbiter #(.GAP_CYCLES(GAP)) dut (
        .clock(clock), .reset(reset), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .ack(ack), .grant(grant), .busy(busy), .cs(cs), .sclk(sclk), .data(data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_cs_low(input string nm);
        int n = 0;
        while (cs !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({nm, "_cs_fall"}, 32'(cs), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // one frame: wait for cs fall, capture 16 bits on sclk-low phases, check ack 32 clocks later
    task automatic frame(input string nm, input logic [3:0] r, input logic [3:0] eg,
                         input logic [15:0] ew, input bit hold, input bit chg);
        logic [15:0] w = '0;
        bit ok = 1'b1;
        int n = 0;
        req = r;
        wait_cs_low(nm);
        if (!hold) req = 4'b0000;
        for (int k = 0; k < 32; k++) begin
            if (grant !== eg || busy !== 1'b1 || ack !== 4'b0 || cs !== 1'b0 || sclk !== ~k[0]) ok = 1'b0;
            if (k[0]) w = {w[14:0], data};
            if (chg && k == 10) din0 = 12'hFFF;
            @(negedge clock);
        end
        check({nm, "_word"}, 32'(w), 32'(ew));
        check({nm, "_shift"}, 32'(ok), 32'd1);
        check({nm, "_end"}, {ack, grant, busy, cs, sclk, data}, {eg, 4'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        @(negedge clock);
        check({nm, "_ackpulse"}, {ack, busy}, {4'b0, 1'b1});
        if (!hold) begin
            while (busy !== 1'b0 && n < 50) begin
                @(negedge clock);
                n++;
            end
            check({nm, "_idle"}, {busy, cs}, {1'b0, 1'b1});
        end
    endtask

    initial begin
        int n, prev, acks0, acks2, cnt;
        bit ok;
        tab[0] = '{4'b0010, 4'b0010, 12'hA5C};
        tab[1] = '{4'b1111, 4'b0100, 12'hF0F};
        tab[2] = '{4'b1011, 4'b1000, 12'h8E1};
        tab[3] = '{4'b0011, 4'b0001, 12'h123};
        tab[4] = '{4'b0110, 4'b0010, 12'hA5C};
        tab[5] = '{4'b0001, 4'b0001, 12'h123};
        reset = 1'b1;
        req = 4'b0;
        din0 = 12'h123;
        din1 = 12'hA5C;
        din2 = 12'hF0F;
        din3 = 12'h8E1;
        repeat (2) @(negedge clock);
        check("reset_state", {ack, grant, busy, cs, sclk, data}, {4'b0, 4'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 6; i++)
            frame($sformatf("vec%0d", i), tab[i].r, tab[i].g, {4'b0, tab[i].w}, 1'b0, 1'b0);

        do_reset();
        req = 4'b1111;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (ack === 4'b0 && n < 200);
            check($sformatf("rr_ack%0d", i), 32'(ack), 32'(4'b0001 << (i % 4)));
            if (i > 0) check($sformatf("rr_period%0d", i), cyc - prev, 32 + GAP + 1);
            prev = cyc;
        end
        req = 4'b0;
        repeat (40) @(negedge clock);

        do_reset();
        din0 = 12'h000;
        frame("mid0", 4'b0001, 4'b0001, 16'h0000, 1'b1, 1'b1);
        frame("mid1", 4'b0001, 4'b0001, 16'h0FFF, 1'b0, 1'b0);
        din0 = 12'h123;

        req = 4'b0010;
        wait_cs_low("abort");
        req = 4'b0;
        repeat (11) @(negedge clock);
        #2 reset = 1'b1;
        #1 check("abort_async", {cs, sclk, busy, grant, data}, {1'b1, 1'b1, 1'b0, 4'b0, 1'b0});
        @(negedge clock);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (ack !== 4'b0 || cs !== 1'b1) cnt++;
            @(negedge clock);
        end
        check("abort_noack", cnt, 0);
        frame("rst_a", 4'b1001, 4'b0001, {4'b0, din0}, 1'b0, 1'b0);
        do_reset();
        frame("rst_b", 4'b1000, 4'b1000, {4'b0, din3}, 1'b0, 1'b0);

        req = 4'b0001;
        wait_cs_low("short");
        req = 4'b0;
        @(negedge clock);
        req = 4'b0100;
        @(negedge clock);
        req = 4'b0;
        acks0 = 0;
        acks2 = 0;
        for (int i = 0; i < 80; i++) begin
            if (ack[0] === 1'b1) acks0++;
            if (ack[2] === 1'b1) acks2++;
            @(negedge clock);
        end
        check("short_busy_served", acks0, 1);
        check("short_busy_dropped", acks2, 0);
        req = 4'b0100;
        @(negedge clock);
        req = 4'b0;
        acks2 = 0;
        ok = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (ack[2] === 1'b1) acks2++;
            if (ack[1:0] !== 2'b0 || ack[3] !== 1'b0) ok = 1'b0;
            @(negedge clock);
        end
        check("short_idle_once", acks2, 1);
        check("short_idle_others", 32'(ok), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dac_frame_arbiter.md
DAC_FRAME_ARBITER -- requirements
Module: dac_frame_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, 2, number of clocks cs is held high between frames (legal range 1-15).
REQ-002 Port clock  input  1  system clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  reset, asynchronous and active-high.
REQ-004 Port req  input  4  per-requester level request; bit i requests one DAC frame.
REQ-005 Port din0..din3  input  12 each  sample word of requester i, MSB first on the wire.
REQ-006 Port ack  output  4  one-clock pulse on bit i when requester i's frame completes.
REQ-007 Port grant  output  4  one-hot owner of the frame in progress; zero when not in SHIFT.
REQ-008 Port busy  output  1  high while in SHIFT or GAP.
REQ-009 Port cs  output  1  DAC chip select, active-low.
REQ-010 Port sclk  output  1  DAC serial clock, registered; idle high.
REQ-011 Port data  output  1  DAC serial data, registered.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and GAP.
REQ-013 In IDLE, when any req bit is sampled high, the block SHALL make the round-robin selection on that edge and enter SHIFT.
REQ-014 Round-robin priority: search starts at (last_granted+1) mod 4 and wraps; last_granted resets to 3, so requester 0 has first priority after reset.
REQ-015 On entry to SHIFT, the selected din SHALL be latched into frame = {2'b00 don't-care, 2'b00 normal mode, din[11:0]}.
  - Later changes to din or req SHALL NOT affect the frame in flight.
REQ-016 On entry to SHIFT: cs=0, sclk=1, data=frame[15], grant=one-hot(selected).
REQ-017 SHIFT SHALL last exactly 32 clocks; sclk toggles every clock (1,0,1,0,...).
  - data SHALL update only on clocks where sclk goes 0->1, advancing to the next lower bit.
  - Each bit is stable across its sclk falling edge.
REQ-018 On the clock after bit 0's sclk-low phase:
  - cs=1, sclk=1, data=0, grant=0;
  - ack[selected] pulses high for exactly one clock;
  - state=GAP.
REQ-019 GAP SHALL hold cs=1 for GAP_CYCLES clocks, then return to IDLE; req is not evaluated during SHIFT or GAP.
REQ-020 A requester that holds req high through its ack SHALL be treated as a new request and served again per REQ-014.
  - Requester-side deassertion is the requester's responsibility.
REQ-021 A req bit that drops before it is sampled in IDLE SHALL NOT be served and SHALL NOT receive ack.
REQ-022 With req held continuously, the frame-to-frame period (cs falling to cs falling) SHALL be 32+GAP_CYCLES+1 clocks.
REQ-023 busy SHALL be 1 from SHIFT entry through the last GAP clock, and 0 in IDLE.

Reset
REQ-024 While reset is high, the block SHALL immediately drive cs=1, sclk=1, data=0, ack=0, grant=0, busy=0, state=IDLE, last_granted=3 and counters=0, independent of clock.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no ack.
  - After release, arbitration restarts at requester 0.

Verification
REQ-026 Single request: req=4'b0010, din1=12'hA5C -> one frame.
  - data on the 16 sclk falling edges = 0000_1010_0101_1100;
  - ack=4'b0010 for one clock, 32 clocks after cs falls;
  - grant=4'b0010 during the frame.
REQ-027 All requesting: req=4'b1111 held -> grant order 0,1,2,3,0.
  - Each ack pulse is 35 clocks apart (GAP_CYCLES=2).
REQ-028 Mid-frame change: din0 changed from 12'h000 to 12'hFFF mid-frame -> transmitted word stays 12'h000; the next frame carries 12'hFFF.
REQ-029 Reset at clock 10 of SHIFT -> cs=1 and sclk=1 asynchronously, no ack.
  - After release with req=4'b1000, the next grant=4'b1000.
REQ-030 Short request: req pulse 1 clock wide while busy -> never served, ack stays 4'b0000.
  - Same pulse in IDLE -> served once.
